// File: rtl/fir_feed_pkg.sv
// Shared types and defaults for the FIR sample feeder: state encoding,
// default widths and the {last, data} FIFO entry width.
package fir_feed_pkg;

  localparam int DW_DEF      = 16;
  localparam int TAPS_DEF    = 5;
  localparam int ENTRY_W_DEF = DW_DEF + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } feed_state_t;

  function automatic int entry_w(input int dw);
    return dw + 1;
  endfunction

endpackage

// File: rtl/fir_feed_fifo.sv
// Synchronous FIFO with head/tail pointers and occupancy count; the head
// entry is visible combinationally on rd_data.
module fir_feed_fifo
  import fir_feed_pkg::*;
#(
  parameter int W     = ENTRY_W_DEF,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wr_data,
  output logic [W-1:0]               rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == CNT_MAX);
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[head];

  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= wr_data;
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) tail <= tail + PTR_ONE;
      if (do_pop)  head <= head + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/fir_sample_feeder.sv
// Feeds buffered upstream samples to the filter x input one per clock and
// optionally drains the delay line with TAPS-1 zeros after each frame.
module fir_sample_feeder
  import fir_feed_pkg::*;
#(
  parameter int DW          = DW_DEF,
  parameter int DEPTH       = 8,
  parameter int TAPS        = TAPS_DEF,
  parameter int START_LEVEL = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DW-1:0]          s_data,
  input  logic                   s_valid,
  input  logic                   s_last,
  output logic                   s_ready,
  input  logic                   flush_en,
  output logic [DW-1:0]          x,
  output logic                   x_valid,
  output logic                   x_last,
  output logic                   busy,
  output logic                   underrun,
  output logic [15:0]            sample_cnt,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  output logic [1:0]             state_dbg
);

  localparam int AW  = $clog2(DEPTH);
  localparam int EW  = entry_w(DW);
  localparam int FCW = $clog2(TAPS);
  localparam logic [AW:0]    START_CNT = (AW+1)'(START_LEVEL);
  localparam logic [AW:0]    CNT_ONE   = (AW+1)'(1);
  localparam logic [FCW-1:0] FLUSH_LEN = FCW'(TAPS - 1);
  localparam logic [FCW-1:0] FCNT_ONE  = FCW'(1);

  // Handshake: a sample transfers on a rising edge where s_valid && s_ready;
  // s_ready depends only on occupancy, so a full FIFO never passes through.
  feed_state_t    state, state_nxt;
  logic [FCW-1:0] fcnt, fcnt_nxt;
  logic [EW-1:0]  head;
  logic           push, pop, full, empty;
  logic [AW:0]    last_cnt;
  logic [DW-1:0]  x_nxt;
  logic           x_valid_nxt, x_last_nxt, underrun_set, cnt_inc;

  assign s_ready   = !full;
  assign push      = s_valid && s_ready;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  fir_feed_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data ({s_last, s_data}),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .cnt     (fifo_cnt)
  );

  // Number of stored last-tagged entries, so a short frame can start early.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_cnt <= '0;
    end else begin
      case ({push && s_last, pop && head[EW-1]})
        2'b10:   last_cnt <= last_cnt + CNT_ONE;
        2'b01:   last_cnt <= last_cnt - CNT_ONE;
        default: last_cnt <= last_cnt;
      endcase
    end
  end

  always_comb begin
    state_nxt    = state;
    fcnt_nxt     = fcnt;
    x_nxt        = '0;
    x_valid_nxt  = 1'b0;
    x_last_nxt   = 1'b0;
    pop          = 1'b0;
    underrun_set = 1'b0;
    cnt_inc      = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_cnt >= START_CNT || last_cnt != '0) state_nxt = STREAM;
      end
      STREAM: begin
        if (!empty) begin
          pop         = 1'b1;
          x_nxt       = head[DW-1:0];
          x_valid_nxt = 1'b1;
          cnt_inc     = 1'b1;
          if (head[EW-1]) begin
            if (flush_en) begin
              state_nxt = FLUSH;
              fcnt_nxt  = FLUSH_LEN;
            end else begin
              x_last_nxt = 1'b1;
              state_nxt  = IDLE;
            end
          end
        end else begin
          // The filter still shifts a zero here, so flag the hole.
          underrun_set = 1'b1;
        end
      end
      FLUSH: begin
        x_valid_nxt = 1'b1;
        fcnt_nxt    = fcnt - FCNT_ONE;
        if (fcnt == FCNT_ONE) begin
          x_last_nxt = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      fcnt       <= '0;
      x          <= '0;
      x_valid    <= 1'b0;
      x_last     <= 1'b0;
      underrun   <= 1'b0;
      sample_cnt <= '0;
    end else begin
      state    <= state_nxt;
      fcnt     <= fcnt_nxt;
      x        <= x_nxt;
      x_valid  <= x_valid_nxt;
      x_last   <= x_last_nxt;
      underrun <= underrun | underrun_set;
      if (cnt_inc) sample_cnt <= sample_cnt + 16'd1;
    end
  end

endmodule
